// File: rtl/llc_req_arb.sv
// LLC request arbiter: per-channel request FIFOs feeding a single LLC port,
// round-robin or fixed-priority, with the grant locked while the core stalls.
module llc_req_arb #(
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 64,
  parameter int RR_EN     = 1,
  localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             in_valid,
  output logic [NUM_CH-1:0]             in_ready,
  input  logic [NUM_CH*PAYLOAD_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PAYLOAD_W-1:0]          out_data,
  output logic [CW-1:0]                 out_ch,
  output logic [NUM_CH-1:0]             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = AW + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [PAYLOAD_W-1:0] mem    [NUM_CH][DEPTH];
  logic [AW-1:0]        rd_ptr [NUM_CH];
  logic [AW-1:0]        wr_ptr [NUM_CH];
  logic [NW-1:0]        count  [NUM_CH];

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CW-1:0]     last_grant;
  logic [CW-1:0]     lock_ch;
  logic [CW-1:0]     winner;
  logic              accept;
  state_t            state, state_nxt;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == NW'(DEPTH));
    end
  end

  // Ready depends only on occupancy, never on out_ready.
  assign in_ready  = ~full;
  assign push      = in_valid & in_ready & {NUM_CH{~rst}};
  assign out_valid = |nonempty;
  assign accept    = out_valid & out_ready;

  always_comb begin
    logic          found;
    logic [CW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (RR_EN != 0)
        idx = CW'((32'(last_grant) + 32'd1 + k) % NUM_CH);
      else
        idx = CW'(k);
      if (!found && nonempty[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    out_ch    = '0;
    unique case (state)
      IDLE: begin
        if (out_valid) out_ch = winner;
        if (out_valid && !out_ready) state_nxt = LOCKED;
      end
      LOCKED: begin
        out_ch = lock_ch;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    if (accept) pop[out_ch] = 1'b1;
  end

  assign out_data = mem[out_ch][rd_ptr[out_ch]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lock_ch    <= '0;
      last_grant <= CW'(NUM_CH - 1);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOCKED) lock_ch <= out_ch;
      if (accept) last_grant <= out_ch;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

endmodule

// File: tb/tb_llc_req_arb.sv
// Scoreboard bench for llc_req_arb: round-robin and fixed-priority instances,
// directed vectors with hand-computed grant order.
module tb_llc_req_arb;

  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          rst;
  always #5 clk = ~clk;

  logic [1:0]      in_valid, in_ready, full;
  logic [2*PW-1:0] in_data;
  logic            out_valid, out_ready;
  logic [PW-1:0]   out_data;
  logic [0:0]      out_ch;

  logic [1:0]      fp_in_valid, fp_in_ready, fp_full;
  logic [2*PW-1:0] fp_in_data;
  logic            fp_out_valid, fp_out_ready;
  logic [PW-1:0]   fp_out_data;
  logic [0:0]      fp_out_ch;

  llc_req_arb #(.NUM_CH(2), .DEPTH(2), .PAYLOAD_W(PW), .RR_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .full(full));

  llc_req_arb #(.NUM_CH(2), .DEPTH(2), .PAYLOAD_W(PW), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(fp_in_valid), .in_ready(fp_in_ready),
    .in_data(fp_in_data), .out_valid(fp_out_valid), .out_ready(fp_out_ready),
    .out_data(fp_out_data), .out_ch(fp_out_ch), .full(fp_full));

  int errors = 0;
  int checks = 0;
  logic [PW:0] exp_q[$];
  logic [PW:0] fp_q[$];
  logic [PW:0] rr_e, fp_e;

  function automatic logic [PW:0] mk(input logic ch, input logic [PW-1:0] d);
    return {ch, d};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitors: every accepted beat must match the head of its scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_unexpected: got ch=%0d data=%h expected none", out_ch, out_data);
      end else begin
        rr_e = exp_q.pop_front();
        check("rr_ch", 64'(out_ch), 64'(rr_e[PW]));
        check("rr_data", out_data, rr_e[PW-1:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && fp_out_valid && fp_out_ready) begin
      if (fp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fp_unexpected: got ch=%0d data=%h expected none", fp_out_ch, fp_out_data);
      end else begin
        fp_e = fp_q.pop_front();
        check("fp_ch", 64'(fp_out_ch), 64'(fp_e[PW]));
        check("fp_data", fp_out_data, fp_e[PW-1:0]);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_full", 64'(full), 64'd0);
    rst = 1'b0;
  endtask

  task automatic push(input int ch, input logic [PW-1:0] d);
    int n = 0;
    in_valid[ch] = 1'b1;
    in_data[ch*PW +: PW] = d;
    while (!in_ready[ch] && n < 20) begin cyc(1); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 on ch %0d", ch);
    end
    cyc(1);
    in_valid[ch] = 1'b0;
  endtask

  task automatic push2(input logic [PW-1:0] d0, input logic [PW-1:0] d1);
    in_valid = 2'b11;
    in_data  = {d1, d0};
    check("push2_ready", 64'(in_ready), 64'd3);
    cyc(1);
    in_valid = 2'b00;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin cyc(1); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: got %0d words left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    fp_in_valid = '0; fp_in_data = '0; fp_out_ready = 1'b0;
    cyc(2);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd3);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    rst = 1'b0;

    // Single word, one-cycle latency, gone the cycle after acceptance.
    out_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 64'hA1));
    push(0, 64'hA1);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", out_data, 64'hA1);
    check("t1_ch", 64'(out_ch), 64'd0);
    cyc(1);
    check("t1_valid_after", 64'(out_valid), 64'd0);

    // Round-robin alternation: 0,1,0,1.
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 64'hB0));
    exp_q.push_back(mk(1'b1, 64'hC0));
    exp_q.push_back(mk(1'b0, 64'hB1));
    exp_q.push_back(mk(1'b1, 64'hC1));
    push2(64'hB0, 64'hC0);
    push2(64'hB1, 64'hC1);
    check("t2_full", 64'(full), 64'd3);
    check("t2_ch", 64'(out_ch), 64'd0);
    out_ready = 1'b1;
    drain("t2_drain");
    out_ready = 1'b0;

    // Channel 1 fills, third word waits, then drains in order through the wrap.
    do_reset();
    push(1, 64'hD0);
    push(1, 64'hD1);
    check("t3_full", 64'(full), 64'd2);
    check("t3_in_ready", 64'(in_ready), 64'd1);
    in_valid[1] = 1'b1;
    in_data[PW +: PW] = 64'hD2;
    cyc(2);
    check("t3_full_hold", 64'(full), 64'd2);
    check("t3_head", out_data, 64'hD0);
    exp_q.push_back(mk(1'b1, 64'hD0));
    exp_q.push_back(mk(1'b1, 64'hD1));
    exp_q.push_back(mk(1'b1, 64'hD2));
    out_ready = 1'b1;
    push(1, 64'hD2);
    check("t3_push_pop_full", 64'(full), 64'd0);
    check("t3_wrap_data", out_data, 64'hD2);
    drain("t3_drain");
    out_ready = 1'b0;

    // Grant held on channel 1 while channel 0 fills behind it.
    do_reset();
    exp_q.push_back(mk(1'b1, 64'hE0));
    exp_q.push_back(mk(1'b0, 64'hF0));
    exp_q.push_back(mk(1'b0, 64'hF1));
    push(1, 64'hE0);
    push(0, 64'hF0);
    check("t4_lock_ch", 64'(out_ch), 64'd1);
    check("t4_lock_data", out_data, 64'hE0);
    push(0, 64'hF1);
    check("t4_full", 64'(full), 64'd1);
    cyc(2);
    check("t4_hold_ch", 64'(out_ch), 64'd1);
    check("t4_hold_data", out_data, 64'hE0);
    out_ready = 1'b1;
    drain("t4_drain");
    out_ready = 1'b0;

    // Reset with buffered words discards them; in_valid during reset ignored.
    do_reset();
    push(0, 64'h60);
    push(1, 64'h61);
    check("t5_buffered", 64'(out_valid), 64'd1);
    rst = 1'b1;
    in_valid = 2'b11;
    in_data = {64'hDEAD, 64'hBEEF};
    cyc(1);
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_full", 64'(full), 64'd0);
    cyc(1);
    rst = 1'b0;
    in_valid = 2'b00;
    check("t5_ignored", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    cyc(3);
    check("t5_no_stale", 64'(out_valid), 64'd0);
    exp_q.push_back(mk(1'b0, 64'h70));
    push(0, 64'h70);
    drain("t5_drain");

    // Fixed priority: channel 0 drains completely before channel 1.
    fp_q.push_back(mk(1'b0, 64'h90));
    fp_q.push_back(mk(1'b0, 64'h91));
    fp_q.push_back(mk(1'b1, 64'hA0));
    fp_q.push_back(mk(1'b1, 64'hA1));
    fp_in_valid = 2'b11;
    fp_in_data = {64'hA0, 64'h90};
    check("fp_ready0", 64'(fp_in_ready), 64'd3);
    cyc(1);
    fp_in_data = {64'hA1, 64'h91};
    check("fp_ready1", 64'(fp_in_ready), 64'd3);
    cyc(1);
    fp_in_valid = 2'b00;
    check("fp_full", 64'(fp_full), 64'd3);
    check("fp_first_ch", 64'(fp_out_ch), 64'd0);
    fp_out_ready = 1'b1;
    for (int n = 0; n < 40 && fp_q.size() != 0; n++) cyc(1);
    if (fp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL fp_drain: got %0d words left expected 0", fp_q.size());
    end
    cyc(1);
    check("fp_empty", 64'(fp_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/llc_req_arb.md
LLC_REQ_ARB -- requirements
Module: llc_req_arb

Interface
REQ-001 Parameter NUM_CH, default 2, SHALL set the number of request input channels (channel 0 = coherence requests, channel 1 = DMA requests); legal range 2..8.
REQ-002 Parameter DEPTH, default 2, SHALL set the per-channel FIFO depth in entries; legal values are powers of two, 2..16.
REQ-003 Parameter PAYLOAD_W, default 64, SHALL set the width of one packed request word.
REQ-004 Parameter RR_EN, default 1, SHALL select arbitration: 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 in_valid  in  NUM_CH  per-channel request valid.
REQ-008 in_ready  out  NUM_CH  per-channel request ready.
REQ-009 in_data  in  NUM_CH*PAYLOAD_W  packed payloads; channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-010 out_valid  out  1  request available to the LLC core.
REQ-011 out_ready  in  1  LLC core accepts the request.
REQ-012 out_data  out  PAYLOAD_W  granted payload.
REQ-013 out_ch  out  max(1,$clog2(NUM_CH))  index of the granted channel.
REQ-014 full  out  NUM_CH  per-channel FIFO-full status flag.

Function
REQ-015 Each channel SHALL own a DEPTH-entry FIFO with a read pointer, a write pointer and an occupancy counter of width $clog2(DEPTH)+1.
REQ-016 in_ready[i] SHALL equal NOT full[i], where full[i] = (count[i]==DEPTH); there SHALL be no combinational path from out_ready to in_ready.
REQ-017 A push on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at the clock edge; the write pointer SHALL wrap modulo DEPTH.
REQ-018 A pop on the granted channel SHALL occur when out_valid and out_ready are both high; the read pointer SHALL wrap modulo DEPTH.
REQ-019 A simultaneous push and pop on the same channel SHALL leave count unchanged and advance both pointers.
REQ-020 Minimum latency SHALL be 1 cycle: a word pushed at edge N is presentable on out_data in the cycle following edge N.
REQ-021 There SHALL be no combinational path from any in_* input to out_valid, out_data or out_ch; these outputs SHALL derive from registers only.
REQ-022 out_valid SHALL be high whenever any count[i] is non-zero.
REQ-023 The arbiter SHALL have two states, IDLE and LOCKED. In IDLE, out_ch SHALL be the arbitration winner among non-empty channels.
REQ-024 The arbiter SHALL go from IDLE to LOCKED when out_valid is high and out_ready is low, latching out_ch.
REQ-025 In LOCKED, out_ch and out_data SHALL hold stable until acceptance, after which the arbiter SHALL return to IDLE.
REQ-026 With RR_EN=1, the search SHALL start at channel last_grant+1 (mod NUM_CH); last_grant SHALL update only on an accepted transfer.
REQ-027 With RR_EN=0, the lowest-index non-empty channel SHALL win; starvation of higher indices is permitted.
REQ-028 out_data SHALL equal the head entry of FIFO[out_ch]; when out_valid is low, out_data SHALL be don't-care and out_ch SHALL be 0.
REQ-029 Payload bits SHALL pass unmodified; the block SHALL perform no field repacking.

Reset
REQ-030 While rst is high: all counts, pointers and full SHALL be 0; out_valid SHALL be 0; the state SHALL be IDLE; last_grant SHALL be NUM_CH-1, so channel 0 wins first; in_valid SHALL be ignored.
REQ-031 A reset asserted mid-transfer SHALL discard all buffered and locked requests at the next edge with no output beat.
REQ-032 FIFO storage arrays SHALL require no reset.

Verification
REQ-033 Channel 0 pushes 0xA1, with out_ready=1 -> the next cycle shows out_valid=1, out_data=0xA1, out_ch=0; out_valid=0 the cycle after.
REQ-034 RR_EN=1, both channels continuously non-empty, out_ready=1 -> the out_ch sequence is 0,1,0,1.
REQ-035 RR_EN=0, same stimulus -> out_ch=0 until channel 0 empties.
REQ-036 DEPTH=2, channel 1 receives 3 pushes with out_ready=0 -> full[1]=1 and in_ready[1]=0 after 2 pushes; the third word waits. Then out_ready=1 -> words drain in order and pointers wrap correctly.
REQ-037 Grant to channel 1 is held with out_ready=0 while channel 0 fills -> out_ch stays 1 and out_data is stable until acceptance.
REQ-038 rst is pulsed with 2 words buffered -> out_valid=0 and full=0 the next cycle, and no stale word appears after reset.
